// File: rtl/div_operand_collector.sv
// ---------------------------------------------------------------------------
// div_operand_collector
//
// Front-end for the signed fixed-point long divider. It assembles a framed
// byte stream into a signed dividend and a signed divisor, then offers the
// pair to the divider over a valid/ready handshake. Each operand is DATA_W
// bits wide and sent MSB byte first. The dividend is sent before the divisor.
//
// Ports:
//   i_clk, i_reset      clock (rising edge), asynchronous active-high reset
//   i_data, i_valid     stream byte and its valid qualifier
//   i_sof               marks the first byte of a frame (qualified by i_valid)
//   o_ready             byte accepted when i_valid && o_ready
//   o_dividend          assembled dividend (meaningful while o_valid)
//   o_divisor           assembled divisor  (meaningful while o_valid)
//   o_quot_neg          sign of the quotient: dividend MSB xor divisor MSB
//   o_div_by_zero       divisor is zero
//   o_valid, i_ready    operand-pair handshake towards the divider
//   o_frame_err         one-cycle pulse on stray byte, restart or timeout
// ---------------------------------------------------------------------------
module div_operand_collector #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    input  logic              i_sof,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_dividend,
    output logic [DATA_W-1:0] o_divisor,
    output logic              o_quot_neg,
    output logic              o_div_by_zero,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frame_err
);

    localparam int NB          = DATA_W / 8;
    localparam int FRAME_BYTES = 2 * NB;
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam int TCNT_W      = $clog2(TIMEOUT + 1);
    localparam int SH_W        = 2 * DATA_W - 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        byte_cnt;
    logic [TCNT_W-1:0]       idle_cnt;
    logic [SH_W-1:0]         shift_q;
    logic [2*DATA_W-1:0]     frame_word;
    logic                    accept;
    logic                    last_byte;
    logic                    timed_out;

    // The shifter keeps only the first 2*NB-1 bytes. The final byte is
    // appended on the fly, so the completed frame can be registered
    // straight into the outputs on the accepting edge.
    assign accept     = i_valid && o_ready;
    assign frame_word = {shift_q, i_data};
    assign last_byte  = (byte_cnt == CNT_W'(FRAME_BYTES - 1));
    assign timed_out  = (idle_cnt == TCNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Within a frame, a start-of-frame byte always
    // restarts collection, even when it lands in the last byte position.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && i_sof) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (!i_sof && last_byte) begin
                        state_nxt = HOLD;
                    end
                end else if (timed_out) begin
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode directly from the state. HOLD is the only
    // state that blocks the stream, so a transfer cycle never accepts a byte.
    always_comb begin
        o_ready = (state != HOLD);
        o_valid = (state == HOLD);
    end

    // Datapath: byte assembly, idle counter, registered operands and the
    // framing-error pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q       <= '0;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
            o_dividend    <= '0;
            o_divisor     <= '0;
            o_quot_neg    <= 1'b0;
            o_div_by_zero <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (i_sof) begin
                            shift_q  <= SH_W'(i_data);
                            byte_cnt <= CNT_W'(1);
                            idle_cnt <= '0;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (i_sof) begin
                            o_frame_err <= 1'b1;
                            shift_q     <= SH_W'(i_data);
                            byte_cnt    <= CNT_W'(1);
                        end else if (last_byte) begin
                            o_dividend    <= frame_word[2*DATA_W-1:DATA_W];
                            o_divisor     <= frame_word[DATA_W-1:0];
                            o_quot_neg    <= frame_word[2*DATA_W-1] ^ frame_word[DATA_W-1];
                            o_div_by_zero <= (frame_word[DATA_W-1:0] == '0);
                            byte_cnt      <= '0;
                        end else begin
                            shift_q  <= frame_word[SH_W-1:0];
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end else if (timed_out) begin
                        // The counter stops at TIMEOUT as the frame is dropped.
                        idle_cnt    <= TCNT_W'(TIMEOUT);
                        byte_cnt    <= '0;
                        o_frame_err <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TCNT_W'(1);
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        byte_cnt <= '0;
                    end
                end
                default: begin
                    byte_cnt <= '0;
                end
            endcase
        end
    end

endmodule
